// File: rtl/btn_pkg.sv
// Shared definitions for the push-button conditioning logic: debounce FSM
// state encoding, default cycle constants and a small state helper.
package btn_pkg;

    // Debounce FSM states; DOWN and ARM_UP both mean "currently pressed".
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ARM_DOWN = 2'b01,
        ST_DOWN     = 2'b11,
        ST_ARM_UP   = 2'b10
    } btn_state_t;

    localparam int DEFAULT_DEBOUNCE_WIDTH  = 16;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 50000;
    localparam int DEFAULT_LONG_WIDTH      = 24;
    localparam int DEFAULT_LONG_CYCLES     = 12000000;

    // True while the debounced level is high (pressed or arming a release).
    function automatic logic is_held(input btn_state_t s);
        return (s == ST_DOWN) || (s == ST_ARM_UP);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser with asynchronous active-high reset.
// Both stages clear to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;
    logic s2;

    // Two back-to-back flops to resolve metastability on the async input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;

endmodule

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser followed by a counter-based
// debounce FSM producing a clean level plus one-cycle press/release pulses.
// The release pulse port is named release_pulse because "release" is a
// reserved word in SystemVerilog.
// Optional long-press detection is compiled in with the macro
// BUTTON_DEBOUNCE_LONG_PRESS_EN; without it long_press is tied to 0.
module button_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_WIDTH  = DEFAULT_DEBOUNCE_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter int LONG_WIDTH      = DEFAULT_LONG_WIDTH,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
    output logic button_level,
    output logic press,
    output logic release_pulse,
    output logic long_press
);

    localparam logic [DEBOUNCE_WIDTH-1:0] DEB_LAST = DEBOUNCE_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEBOUNCE_WIDTH-1:0] DEB_ONE  = DEBOUNCE_WIDTH'(1);

    logic                      sync_q;
    logic                      b;
    btn_state_t                state;
    btn_state_t                state_next;
    logic [DEBOUNCE_WIDTH-1:0] cnt;
    logic [DEBOUNCE_WIDTH-1:0] cnt_next;
    logic                      level_next;
    logic                      press_next;
    logic                      release_next;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_in),
        .q   (sync_q)
    );

    // Polarity is normalised after the synchroniser so b=1 always means pressed.
    assign b = sync_q ^ ACTIVE_LOW;

    // Next-state logic: the compare against DEB_LAST precedes the increment,
    // so the stability counter can never wrap.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        level_next   = button_level;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            ST_IDLE: begin
                if (b) begin
                    state_next = ST_ARM_DOWN;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_ARM_DOWN: begin
                if (!b) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = ST_DOWN;
                    cnt_next   = '0;
                    level_next = 1'b1;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + DEB_ONE;
                end
            end
            ST_DOWN: begin
                if (!b) begin
                    state_next = ST_ARM_UP;
                    cnt_next   = '0;
                end else begin
                    state_next = ST_DOWN;
                end
            end
            ST_ARM_UP: begin
                if (b) begin
                    state_next = ST_DOWN;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next   = ST_IDLE;
                    cnt_next     = '0;
                    level_next   = 1'b0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + DEB_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                level_next = 1'b0;
            end
        endcase
    end

    // FSM state, stability counter and registered level/pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            button_level  <= 1'b0;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            button_level  <= level_next;
            press         <= press_next;
            release_pulse <= release_next;
        end
    end

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam logic [LONG_WIDTH-1:0] LONG_LAST = LONG_WIDTH'(LONG_CYCLES - 1);
    localparam logic [LONG_WIDTH-1:0] LONG_SAT  = LONG_WIDTH'(LONG_CYCLES);
    localparam logic [LONG_WIDTH-1:0] LONG_ONE  = LONG_WIDTH'(1);

    logic [LONG_WIDTH-1:0] lcnt;
    logic [LONG_WIDTH-1:0] lcnt_next;
    logic                  long_next;

    // Held-time counter: runs through DOWN and ARM_UP (a release bounce does
    // not restart it) and parks at LONG_SAT so only one pulse fires per press.
    // Any state outside the held pair clears it, which covers entering DOWN
    // from ARM_DOWN and returning to IDLE.
    always_comb begin
        lcnt_next = lcnt;
        long_next = 1'b0;
        if (is_held(state)) begin
            long_next = (lcnt == LONG_LAST);
            if (state_next == ST_IDLE) begin
                lcnt_next = '0;
            end else if (lcnt != LONG_SAT) begin
                lcnt_next = lcnt + LONG_ONE;
            end else begin
                lcnt_next = lcnt;
            end
        end else begin
            lcnt_next = '0;
        end
    end

    // Long-press counter and registered pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcnt       <= '0;
            long_press <= 1'b0;
        end else begin
            lcnt       <= lcnt_next;
            long_press <= long_next;
        end
    end
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed, table-driven bench for button_debounce (DEBOUNCE_CYCLES=8,
// LONG_CYCLES=20). One instance is active-high, one active-low. Expected
// pulse positions are step indices counted from the first step after reset;
// a level driven in step k is first sampled by edge k.
module tb_button_debounce;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic bin0 = 1'b0;
    logic bin1 = 1'b1;
    logic lvl0, pr0, rl0, lp0;
    logic lvl1, pr1, rl1, lp1;

    button_debounce #(
        .DEBOUNCE_WIDTH (16), .DEBOUNCE_CYCLES (8), .ACTIVE_LOW (1'b0),
        .LONG_WIDTH (24), .LONG_CYCLES (20)
    ) dut (
        .clk (clk), .rst (rst), .button_in (bin0), .button_level (lvl0),
        .press (pr0), .release_pulse (rl0), .long_press (lp0)
    );

    button_debounce #(
        .DEBOUNCE_WIDTH (16), .DEBOUNCE_CYCLES (8), .ACTIVE_LOW (1'b1),
        .LONG_WIDTH (24), .LONG_CYCLES (20)
    ) dut_al (
        .clk (clk), .rst (rst), .button_in (bin1), .button_level (lvl1),
        .press (pr1), .release_pulse (rl1), .long_press (lp1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit alow;
        bit v0; int l0; bit v1; int l1; bit v2; int l2; bit v3; int l3;
        int press_n; int press_at;
        int rel_n;   int rel_at;
        int long_n;  int long_at;
        bit level_end;
    } vec_t;

    vec_t vecs [5];

    int checks = 0;
    int errors = 0;
    int cyc;
    int n_press, at_press, n_rel, at_rel, n_long, at_long;
    bit sel_al = 1'b0;
    logic prev0, prev1;

    function automatic vec_t mk(input bit al,
                                input bit v0, input int l0, input bit v1, input int l1,
                                input bit v2, input int l2, input bit v3, input int l3,
                                input int pn, input int pa, input int rn, input int ra,
                                input int ln, input int la, input bit le);
        vec_t v;
        v.alow = al;
        v.v0 = v0; v.l0 = l0; v.v1 = v1; v.l1 = l1;
        v.v2 = v2; v.l2 = l2; v.v3 = v3; v.l3 = l3;
        v.press_n = pn; v.press_at = pa; v.rel_n = rn; v.rel_at = ra;
        v.long_n = ln; v.long_at = la; v.level_end = le;
        return v;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_log();
        n_press = 0; at_press = -1;
        n_rel   = 0; at_rel   = -1;
        n_long  = 0; at_long  = -1;
    endtask

    // One clock: sample #1 after the edge, check invariants, log pulses.
    task automatic step();
        logic p, r, l;
        @(posedge clk);
        #1;
        cyc++;
        check("dut0_press_release_exclusive", int'(pr0 & rl0), 0);
        check("dut1_press_release_exclusive", int'(pr1 & rl1), 0);
        if (!rst && (lvl0 !== prev0))
            check("dut0_level_moves_with_pulse", int'(lvl0 ? pr0 : rl0), 1);
        if (!rst && (lvl1 !== prev1))
            check("dut1_level_moves_with_pulse", int'(lvl1 ? pr1 : rl1), 1);
        prev0 = lvl0;
        prev1 = lvl1;
        p = sel_al ? pr1 : pr0;
        r = sel_al ? rl1 : rl0;
        l = sel_al ? lp1 : lp0;
        if (p) begin n_press++; if (at_press < 0) at_press = cyc; end
        if (r) begin n_rel++;   if (at_rel   < 0) at_rel   = cyc; end
        if (l) begin n_long++;  if (at_long  < 0) at_long  = cyc; end
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            if (sel_al) bin1 = v;
            else        bin0 = v;
            step();
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        bin0 = 1'b0;
        bin1 = 1'b1;
        step();
        step();
        check("reset_level0", int'(lvl0), 0);
        check("reset_press0", int'(pr0), 0);
        check("reset_release0", int'(rl0), 0);
        check("reset_long0", int'(lp0), 0);
        check("reset_level1", int'(lvl1), 0);
        check("reset_pulses1", int'(pr1 | rl1 | lp1), 0);
        rst   = 1'b0;
        prev0 = lvl0;
        prev1 = lvl1;
        cyc   = -1;
        clear_log();
    endtask

    initial begin
        // alow | segments (value,length) x4 | press n,at | release n,at | long n,at | level at end
        vecs[0] = mk(1'b0, 1'b1, 40, 1'b0, 0, 1'b0, 0, 1'b0, 0,
                     1, 10, 0, -1, LP_EN ? 1 : 0, LP_EN ? 30 : -1, 1'b1);
        vecs[1] = mk(1'b0, 1'b1, 5, 1'b0, 1, 1'b1, 30, 1'b0, 0,
                     1, 16, 0, -1, 0, -1, 1'b1);
        vecs[2] = mk(1'b0, 1'b1, 20, 1'b0, 3, 1'b1, 2, 1'b0, 20,
                     1, 10, 1, 35, LP_EN ? 1 : 0, LP_EN ? 30 : -1, 1'b0);
        vecs[3] = mk(1'b0, 1'b1, 60, 1'b0, 20, 1'b0, 0, 1'b0, 0,
                     1, 10, 1, 70, LP_EN ? 1 : 0, LP_EN ? 30 : -1, 1'b0);
        vecs[4] = mk(1'b1, 1'b1, 5, 1'b0, 12, 1'b1, 20, 1'b1, 0,
                     1, 15, 1, 27, 0, -1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            sel_al = vecs[i].alow;
            do_reset();
            hold(vecs[i].v0, vecs[i].l0);
            hold(vecs[i].v1, vecs[i].l1);
            hold(vecs[i].v2, vecs[i].l2);
            hold(vecs[i].v3, vecs[i].l3);
            check($sformatf("v%0d_press_count", i), n_press, vecs[i].press_n);
            check($sformatf("v%0d_press_step", i), at_press, vecs[i].press_at);
            check($sformatf("v%0d_release_count", i), n_rel, vecs[i].rel_n);
            check($sformatf("v%0d_release_step", i), at_rel, vecs[i].rel_at);
            check($sformatf("v%0d_long_count", i), n_long, vecs[i].long_n);
            check($sformatf("v%0d_long_step", i), at_long, vecs[i].long_at);
            check($sformatf("v%0d_level_end", i),
                  int'(sel_al ? lvl1 : lvl0), int'(vecs[i].level_end));
        end

        // Reset in the middle of ARM_DOWN with the button still held: the
        // partial count is dropped and a full debounce restarts at step 8.
        sel_al = 1'b0;
        do_reset();
        hold(1'b1, 6);
        rst = 1'b1;
        hold(1'b1, 2);
        check("midreset_level_in_reset", int'(lvl0), 0);
        check("midreset_no_early_press", n_press, 0);
        rst = 1'b0;
        hold(1'b1, 22);
        check("midreset_press_count", n_press, 1);
        check("midreset_press_step", at_press, 18);
        check("midreset_level_end", int'(lvl0), 1);
        check("midreset_release_count", n_rel, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Conditions a raw mechanical push-button input for the button-gesture logic.
- Performs a 2-flop synchroniser, then a counter-based debounce FSM.
- Outputs a clean level plus one-cycle press/release pulses.
- Sits directly upstream of the click/double-click detector, which consumes button_level.

Parameters:
- DEBOUNCE_WIDTH, 16: width of the stability counter.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a change. Legal range 1 to 2^DEBOUNCE_WIDTH-1.
- ACTIVE_LOW, 0: 1 means the raw input is low when pressed; it is inverted after the synchroniser.
- LONG_WIDTH, 24: width of the long-press counter (used only with the optional feature).
- LONG_CYCLES, 12000000: held cycles in DOWN before long_press fires. Must be at least 1.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, asynchronous, active-high.
- button_in, in, 1: raw asynchronous button pin.
- button_level, out, 1: debounced pressed level.
- press, out, 1: one-cycle pulse on accepted press.
- release, out, 1: one-cycle pulse on accepted release.
- long_press, out, 1: one-cycle pulse when a press is held for LONG_CYCLES. Tied 0 without the feature.

Behaviour:
- Reset (async, rst=1):
  - sync flops s1=s2=0; FSM in IDLE; counters 0.
  - button_level, press, release and long_press all 0.
- Synchroniser: s1<=button_in, s2<=s1 on every posedge. Input b = s2 XOR ACTIVE_LOW.
- FSM states: IDLE (released), ARM_DOWN, DOWN (pressed), ARM_UP.
  - IDLE: if b=1, go to ARM_DOWN with cnt<=0.
  - ARM_DOWN, b=0: bounce rejected; return to IDLE, cnt<=0, no pulse.
  - ARM_DOWN, b=1 and cnt==DEBOUNCE_CYCLES-1: go to DOWN, button_level<=1, press<=1.
  - ARM_DOWN, b=1 otherwise: cnt<=cnt+1.
  - DOWN: if b=0, go to ARM_UP with cnt<=0.
  - ARM_UP, b=1: return to DOWN, no pulse.
  - ARM_UP, b=0 and cnt==DEBOUNCE_CYCLES-1: go to IDLE, button_level<=0, release<=1.
  - ARM_UP, b=0 otherwise: cnt<=cnt+1.
- Latency: let E0 be the first edge sampling button_in asserted.
  - press and button_level are registered at edge E0+DEBOUNCE_CYCLES+2.
  - Release is symmetric.
- Pulse rules:
  - press, release and long_press are registered outputs, high for exactly one cycle, cleared the following cycle.
  - press and release are never high in the same cycle.
  - button_level changes only on the same edge as press/release.
- The counter never wraps, because the compare precedes the increment.
- Reset mid-ARM: the partial count is discarded.
- Button held through reset deassertion: it is treated as a new press and produces press after the full latency.

Optional Feature:
- Macro: BUTTON_DEBOUNCE_LONG_PRESS_EN.
- When defined:
  - lcnt clears on entry to DOWN and increments each cycle in DOWN and ARM_UP.
  - When lcnt==LONG_CYCLES-1, long_press<=1 for one cycle; lcnt then saturates, so there is one pulse per press.
  - A bounce back from ARM_UP to DOWN does not clear lcnt.
  - Entering IDLE clears lcnt.
- When undefined: long_press is constant 0, and the lcnt logic and LONG_* parameters are unused.

Decomposition:
- Shared package btn_pkg holds:
  - the state encoding (IDLE=2'b00, ARM_DOWN=2'b01, DOWN=2'b11, ARM_UP=2'b10);
  - the default debounce/long-press cycle constants.
- One sub-module, sync_2ff: a 1-bit two-flop synchroniser with async reset, reused for other pins.

Test Plan (DEBOUNCE_CYCLES=8, LONG_CYCLES=20, ACTIVE_LOW=0):
- Reset then clean press held 40 cycles: press pulses once at E0+10 with button_level=1; no release.
- Bounce: button_in high for 5 cycles, low 1, high 30: the first burst is rejected; press arrives 10 edges after the final rising sample; exactly one press.
- Release bounce: while DOWN, low 3 cycles, high 2, then low 20: button_level stays 1 during the glitch; one release 10 edges after the final falling sample.
- Reset mid-ARM_DOWN (rst at cycle 5 of the count, released 2 cycles later, button still high): no press before reset; press 10 edges after the first sample post-reset.
- With macro defined, hold 60 cycles: press at +10, long_press exactly once 20 cycles after entering DOWN, then release on let-go. Without macro, long_press stays 0.
- ACTIVE_LOW=1, button_in driven low 12 cycles then high: press at E0+10 and release 10 edges after the return high.
